// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmit stage.
// Holds the FSM state encoding, the default word width and the frame length.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to every frame).
package piso_pkg;

  localparam int DATA_W_DEF = 8;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SHIFT  = 3'b010,
    S_PARITY = 3'b100
  } state_t;
`else
  localparam int PARITY_BITS = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;
`endif

  // Number of serial beats in one frame for a given parallel width.
  function automatic int frame_len(input int data_w);
    return data_w + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_fifo.sv
// Synchronous show-ahead FIFO buffering parallel words ahead of the serializer.
// Ports: clk/rst_n (async active-low), push/wdata, pop/rdata, full/empty,
//        full_next (full flag as it will be after the current edge).
module piso_fifo
  import piso_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              full_next
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_ptr_nxt;
  logic [AW:0]       rd_ptr_nxt;
  logic              do_push;
  logic              do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

  assign full_next = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter: buffers bytes, shifts each out LSB-first.
// Ports: clk_i, rst_n_i (async active-low); data_i/valid_i/ready_o parallel side;
//        ser_data_o/ser_valid_o/ser_ready_i serial side; busy_o activity flag.
// Optional feature macro: PISO_PARITY_EN adds one even-parity beat after the data bits.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              ser_data_o,
  output logic              ser_valid_o,
  input  logic              ser_ready_i,
  output logic              busy_o
);

  localparam int CNT_W     = $clog2(DATA_W + 1);
  localparam int FRAME_LEN = frame_len(DATA_W);
  // Counter value on the final data beat; with parity one more beat follows.
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(FRAME_LEN - PARITY_BITS - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_full_next;

  logic              beat;
  logic              frame_done;
  logic              load;

`ifdef PISO_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign fifo_push = valid_i && ready_q && !fifo_full;

  piso_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (fifo_push),
    .wdata     (data_i),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // ready_o is registered from the post-edge full flag so that a pop in the
  // same cycle as the last free slot being taken reopens it one cycle later.
  assign ready_o = ready_q;
  assign busy_o  = (state_q != S_IDLE) || !fifo_empty;
  assign beat    = ser_valid_o && ser_ready_i;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_valid_o = 1'b0;
    ser_data_o  = 1'b0;
    frame_done  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Loading from IDLE is handled by the common reload path below.
      end

      S_SHIFT: begin
        ser_valid_o = 1'b1;
        ser_data_o  = shreg_q[0];
        if (beat) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_DATA_BIT) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
`else
            frame_done = 1'b1;
`endif
          end
        end
      end

`ifdef PISO_PARITY_EN
      S_PARITY: begin
        ser_valid_o = 1'b1;
        ser_data_o  = parity_q;
        if (beat) begin
          frame_done = 1'b1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new frame starts from IDLE or directly after the last beat of the
    // previous one, which keeps back-to-back frames free of idle cycles.
    load     = ((state_q == S_IDLE) || frame_done) && !fifo_empty;
    fifo_pop = load;

    if (load) begin
      shreg_d = fifo_rdata;
      cnt_d   = '0;
      state_d = S_SHIFT;
`ifdef PISO_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end else if (frame_done) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ready_q  <= !fifo_full_next;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: scoreboard of expected serial bits plus cycle checks.
module tb_piso_serializer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk_i;
  logic          rst_n_i;
  logic [DW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic          ser_data_o;
  logic          ser_valid_o;
  logic          ser_ready_i;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  bit exp_q[$];

  piso_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .ser_data_o  (ser_data_o),
    .ser_valid_o (ser_valid_o),
    .ser_ready_i (ser_ready_i),
    .busy_o      (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: a beat is taken at the next rising edge whenever
  // valid and ready are both high in the preceding low phase.
  always @(negedge clk_i) begin
    if (rst_n_i && ser_valid_o && ser_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_beat", 32'd1, 32'd0);
      end else begin
        chk("sb_bit", {31'd0, ser_data_o}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1. On timeout valid_i stays high.
  task automatic push_byte(input logic [DW-1:0] b, input int budget, output bit ok);
    ok      = 1'b0;
    data_i  = b;
    valid_i = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        for (int k = 0; k < DW; k++) exp_q.push_back(b[k]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^b);
`endif
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        ok      = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (!busy_o && exp_q.size() == 0) break;
    end
    chk({tag, "_busy_low"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nacc;
    int vcnt;

    rst_n_i     = 1'b0;
    data_i      = '0;
    valid_i     = 1'b0;
    ser_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_valid", {31'd0, ser_valid_o}, 32'd0);
    chk("rst_data",  {31'd0, ser_data_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_rst", {31'd0, ready_o}, 32'd1);

    // 1: single byte 0xA5, one-cycle load latency, then idle after 8 beats
    ser_ready_i = 1'b1;
    push_byte(8'hA5, 10, ok);
    chk("t1_accept", {31'd0, ok}, 32'd1);
    chk("t1_valid_pre", {31'd0, ser_valid_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("t1_valid_first", {31'd0, ser_valid_o}, 32'd1);
    chk("t1_bit0", {31'd0, ser_data_o}, 32'd1);
    repeat (8) @(posedge clk_i);
    #1;
    chk("t1_valid_end", {31'd0, ser_valid_o}, 32'd0);
    drain("t1", 20);

    // 2: two bytes back-to-back -> 16 consecutive beats
    push_byte(8'h01, 10, ok);
    push_byte(8'h80, 10, ok);
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      if (ser_valid_o) vcnt++;
    end
    chk("t2_no_gap_beats", vcnt, 32'd16);
    @(posedge clk_i); #1;
    chk("t2_valid_end", {31'd0, ser_valid_o}, 32'd0);
    chk("t2_busy_end", {31'd0, busy_o}, 32'd0);
    drain("t2", 20);

    // 3: stall mid-frame for 5 cycles
    push_byte(8'h5A, 10, ok);
    repeat (4) @(posedge clk_i);
    #1;
    ser_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("t3_stall_valid", {31'd0, ser_valid_o}, 32'd1);
      chk("t3_stall_data", {31'd0, ser_data_o},
          (exp_q.size() != 0) ? {31'd0, exp_q[0]} : 32'hDEAD);
    end
    ser_ready_i = 1'b1;
    drain("t3", 40);

    // 4: DEPTH+2 bytes with the serial side stalled
    ser_ready_i = 1'b0;
    nacc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push_byte(8'h11 * (i + 1), 4, ok);
      if (ok) nacc++;
    end
    chk("t4_accepted", nacc, DEPTH + 1);
    chk("t4_ready_full", {31'd0, ready_o}, 32'd0);
    chk("t4_valid_held", {31'd0, valid_i}, 32'd1);
    ser_ready_i = 1'b1;
    push_byte(8'h11 * (DEPTH + 2), 40, ok);
    chk("t4_last_accept", {31'd0, ok}, 32'd1);
    drain("t4", 100);

    // 5: reset at bit 3 of 0xFF, then fresh frame
    push_byte(8'hFF, 10, ok);
    repeat (4) @(posedge clk_i);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, ser_valid_o}, 32'd0);
    chk("t5_rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("t5_rst_ready", {31'd0, ready_o}, 32'd0);
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("t5_ready_back", {31'd0, ready_o}, 32'd1);
    chk("t5_fifo_empty", {31'd0, busy_o}, 32'd0);
    push_byte(8'h3C, 10, ok);
    @(posedge clk_i); #1;
    chk("t5_fresh_valid", {31'd0, ser_valid_o}, 32'd1);
    chk("t5_fresh_bit0", {31'd0, ser_data_o}, 32'd0);
    drain("t5", 40);

`ifdef PISO_PARITY_EN
    // 6: parity beat for 0x07 (odd ones -> 1) and 0x03 (even -> 0)
    push_byte(8'h07, 10, ok);
    push_byte(8'h03, 10, ok);
    drain("t6", 60);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
